// File: rtl/eeprom_pkg.sv
// rtl/eeprom_pkg.sv - shared encodings for the EEPROM controller
//
// Purpose: byte-engine command codes, controller state enum, default device
//          address and small state-classification helpers.
// Ports:   none (package).
// Build:   EEPROM_CTRL_ACKPOLL_EN adds the ACK-poll states to the enum.

package eeprom_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010000;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_STOP  = 2'd3
  } cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DEVW,
    ST_WADDR,
    ST_WDATA,
    ST_RSTART,
    ST_DEVR,
    ST_RDATA,
    ST_STOP,
    ST_WR_WAIT,
    ST_FIN
`ifdef EEPROM_CTRL_ACKPOLL_EN
    , ST_POLL_START,
    ST_POLL_DEV,
    ST_POLL_STOP
`endif
  } state_e;

  // States that hand exactly one command to the byte engine.
  function automatic logic is_cmd_state(input state_e s);
    return s inside {ST_START, ST_DEVW, ST_WADDR, ST_WDATA, ST_RSTART,
                     ST_DEVR, ST_RDATA, ST_STOP
`ifdef EEPROM_CTRL_ACKPOLL_EN
                     , ST_POLL_START, ST_POLL_DEV, ST_POLL_STOP
`endif
                     };
  endfunction

  // WRITE states whose slave NACK aborts the transaction.
  function automatic logic is_ack_checked(input state_e s);
    return s inside {ST_DEVW, ST_WADDR, ST_WDATA, ST_DEVR};
  endfunction

endpackage

// File: rtl/eeprom_ctrl_if.sv
// rtl/eeprom_ctrl_if.sv - command bus between controller and I2C byte engine
//
// Purpose: bundles the command handshake and the byte-completion return path.
// Signals: cmd_valid/cmd/cmd_byte/cmd_nack (controller -> engine),
//          cmd_ready/byte_done/byte_rdata/byte_nack (engine -> controller).
// Modports: master = controller side, slave = byte-engine side.

interface eeprom_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [7:0] cmd_byte;
  logic       cmd_nack;
  logic       cmd_ready;
  logic       byte_done;
  logic [7:0] byte_rdata;
  logic       byte_nack;

  modport master (
    output cmd_valid, cmd, cmd_byte, cmd_nack,
    input  cmd_ready, byte_done, byte_rdata, byte_nack
  );

  modport slave (
    input  cmd_valid, cmd, cmd_byte, cmd_nack,
    output cmd_ready, byte_done, byte_rdata, byte_nack
  );
endinterface

// File: rtl/eeprom_wait_cnt.sv
// rtl/eeprom_wait_cnt.sv - loadable down-counter with zero flag
//
// Purpose: times the post-write delay (or counts remaining ACK polls).
// Ports:   clk, srst (sync active-high), load + load_val (preset),
//          en (decrement while non-zero), zero (count is zero).

module eeprom_wait_cnt #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/eeprom_ctrl.sv
// rtl/eeprom_ctrl.sv - 24Cxx byte-write / random-read controller
//
// Purpose: sequences START/WRITE/READ/STOP commands to an I2C byte engine for
//          single-byte writes (followed by the write-cycle wait) and random reads.
// Ports:   clk, srst (sync active-high reset shared with the engine),
//          wr_req/rd_req/addr/wdata (host request), busy/done/ack_err/rdata
//          (host status), eng (command bus, master side).
// Build:   EEPROM_CTRL_ACKPOLL_EN replaces the fixed write wait with ACK polling
//          bounded by POLL_MAX attempts.

module eeprom_ctrl
  import eeprom_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int unsigned WR_WAIT  = 250000,
  parameter int unsigned POLL_MAX = 255
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         wr_req,
  input  logic         rd_req,
  input  logic [7:0]   addr,
  input  logic [7:0]   wdata,
  output logic         busy,
  output logic         done,
  output logic         ack_err,
  output logic [7:0]   rdata,
  eeprom_ctrl_if.master eng
);

  // One counter serves either the wait delay or the poll budget.
  localparam int unsigned CNT_MAX = (WR_WAIT > POLL_MAX) ? WR_WAIT : POLL_MAX;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state;
  state_e           state_next;
  logic             pending;    // command accepted, waiting for byte_done
  logic             is_read;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;
  logic             accept;
  logic             step;       // current command completed
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
`ifdef EEPROM_CTRL_ACKPOLL_EN
  logic             poll_nack;
`endif

  assign accept = (state == ST_IDLE) && (wr_req || rd_req);
  assign step   = pending && eng.byte_done;

  // State register
  always_ff @(posedge clk) begin
    if (srst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch, handshake tracking and status registers
  always_ff @(posedge clk) begin
    if (srst) begin
      pending   <= 1'b0;
      is_read   <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      ack_err   <= 1'b0;
      rdata     <= 8'h00;
`ifdef EEPROM_CTRL_ACKPOLL_EN
      poll_nack <= 1'b0;
`endif
    end else begin
      if (accept) begin
        is_read <= !wr_req;     // write wins when both are requested
        addr_q  <= addr;
        wdata_q <= wdata;
        ack_err <= 1'b0;
      end
      if (step) begin
        pending <= 1'b0;
      end else if (eng.cmd_valid && eng.cmd_ready) begin
        pending <= 1'b1;
      end
      if (step && eng.byte_nack && is_ack_checked(state)) begin
        ack_err <= 1'b1;
      end
      if (step && (state == ST_RDATA)) begin
        rdata <= eng.byte_rdata;
      end
`ifdef EEPROM_CTRL_ACKPOLL_EN
      if (step && (state == ST_POLL_DEV)) begin
        poll_nack <= eng.byte_nack;
      end
      if (step && (state == ST_POLL_STOP) && poll_nack && cnt_zero) begin
        ack_err <= 1'b1;
      end
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (wr_req || rd_req) state_next = ST_START;
      ST_START:   if (step) state_next = ST_DEVW;
      ST_DEVW:    if (step) state_next = eng.byte_nack ? ST_STOP : ST_WADDR;
      ST_WADDR:   if (step) state_next = eng.byte_nack ? ST_STOP :
                                         (is_read ? ST_RSTART : ST_WDATA);
      ST_WDATA:   if (step) state_next = ST_STOP;
      ST_RSTART:  if (step) state_next = ST_DEVR;
      ST_DEVR:    if (step) state_next = eng.byte_nack ? ST_STOP : ST_RDATA;
      ST_RDATA:   if (step) state_next = ST_STOP;
      ST_STOP: begin
        if (step) begin
          // ack_err already reflects any NACK seen earlier in this transaction
          if (is_read || ack_err) begin
            state_next = ST_FIN;
          end else begin
`ifdef EEPROM_CTRL_ACKPOLL_EN
            state_next = ST_POLL_START;
`else
            state_next = ST_WR_WAIT;
`endif
          end
        end
      end
      ST_WR_WAIT: if (cnt_zero) state_next = ST_FIN;
      ST_FIN:     state_next = ST_IDLE;
`ifdef EEPROM_CTRL_ACKPOLL_EN
      ST_POLL_START: if (step) state_next = ST_POLL_DEV;
      ST_POLL_DEV:   if (step) state_next = ST_POLL_STOP;
      ST_POLL_STOP: begin
        if (step) begin
          state_next = (poll_nack && !cnt_zero) ? ST_POLL_START : ST_FIN;
        end
      end
`endif
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs: decoded from state only, so cmd_valid never depends on cmd_ready
  always_comb begin
    busy          = (state != ST_IDLE) && (state != ST_FIN);
    done          = (state == ST_FIN);
    eng.cmd_valid = is_cmd_state(state) && !pending;
    eng.cmd       = CMD_START;
    eng.cmd_byte  = 8'h00;
    eng.cmd_nack  = 1'b0;
    case (state)
      ST_DEVW: begin
        eng.cmd      = CMD_WRITE;
        eng.cmd_byte = {DEV_ADDR, 1'b0};
      end
      ST_WADDR: begin
        eng.cmd      = CMD_WRITE;
        eng.cmd_byte = addr_q;
      end
      ST_WDATA: begin
        eng.cmd      = CMD_WRITE;
        eng.cmd_byte = wdata_q;
      end
      ST_DEVR: begin
        eng.cmd      = CMD_WRITE;
        eng.cmd_byte = {DEV_ADDR, 1'b1};
      end
      ST_RDATA: begin
        eng.cmd      = CMD_READ;
        eng.cmd_nack = 1'b1;    // single-byte read ends with master NACK
      end
      ST_STOP: eng.cmd = CMD_STOP;
`ifdef EEPROM_CTRL_ACKPOLL_EN
      ST_POLL_DEV: begin
        eng.cmd      = CMD_WRITE;
        eng.cmd_byte = {DEV_ADDR, 1'b0};
      end
      ST_POLL_STOP: eng.cmd = CMD_STOP;
`endif
      default: ;
    endcase
  end

  // Counter control: preset on leaving STOP of a clean write
`ifdef EEPROM_CTRL_ACKPOLL_EN
  assign cnt_load     = step && (state == ST_STOP) && (state_next == ST_POLL_START);
  assign cnt_load_val = CNT_W'(POLL_MAX);
  assign cnt_en       = step && (state == ST_POLL_DEV) && eng.byte_nack;
`else
  // Preset to WR_WAIT-1 so the count reaches zero after exactly WR_WAIT cycles
  assign cnt_load     = step && (state == ST_STOP) && (state_next == ST_WR_WAIT);
  assign cnt_load_val = CNT_W'(WR_WAIT - 1);
  assign cnt_en       = (state == ST_WR_WAIT);
`endif

  eeprom_wait_cnt #(
    .WIDTH(CNT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .srst    (srst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .en      (cnt_en),
    .zero    (cnt_zero)
  );

endmodule

// File: doc/eeprom_ctrl.md
EEPROM_CTRL -- requirements
Module: eeprom_ctrl

Interface
REQ-001 Parameter DEV_ADDR, default 7'b1010000: 7-bit I2C device address (24C02).
REQ-002 Parameter WR_WAIT, default 250000: write-cycle wait in clk cycles (5 ms at 50 MHz).
REQ-003 Parameter POLL_MAX, default 255: maximum ACK-poll attempts (EEPROM_CTRL_ACKPOLL_EN builds only).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 srst  in  1  synchronous, active-high reset.
REQ-007 wr_req  in  1  single-cycle byte-write request.
REQ-008 rd_req  in  1  single-cycle random-read request.
REQ-009 addr  in  8  EEPROM word address.
REQ-010 wdata  in  8  byte to write.
REQ-011 busy  out  1  transaction in progress.
REQ-012 done  out  1  one-cycle pulse at transaction end.
REQ-013 ack_err  out  1  status of last transaction; valid with done, held until next accept.
REQ-014 rdata  out  8  last read byte; held until next read completes.
REQ-015 cmd_valid  out  1  command to byte engine valid.
REQ-016 cmd  out  2  0 START, 1 WRITE, 2 READ, 3 STOP.
REQ-017 cmd_byte  out  8  byte for WRITE.
REQ-018 cmd_nack  out  1  for READ: 1 = master NACKs the byte.
REQ-019 cmd_ready  in  1  engine accepts command this cycle.
REQ-020 byte_done  in  1  one-cycle pulse when accepted command completes.
REQ-021 byte_rdata  in  8  read byte, valid with byte_done.
REQ-022 byte_nack  in  1  slave NACKed WRITE, valid with byte_done.

Function
REQ-023 Requests are sampled only when busy=0; requests while busy are ignored; wr_req and rd_req together -> write executes, read dropped.
REQ-024 On accept, addr/wdata latch, ack_err clears, busy rises the next cycle.
REQ-025 FSM states: IDLE, START, DEVW, WADDR, WDATA, RSTART, DEVR, RDATA, STOP, WR_WAIT, FIN.
REQ-026 Write: START -> DEVW ({DEV_ADDR,0}) -> WADDR (addr) -> WDATA (wdata) -> STOP -> WR_WAIT -> FIN.
REQ-027 Read: START -> DEVW -> WADDR -> RSTART (START) -> DEVR ({DEV_ADDR,1}) -> RDATA (READ, cmd_nack=1) -> STOP -> FIN.
REQ-028 Each state drives cmd_valid=1 with stable cmd/cmd_byte until cmd_ready=1 (accept cycle); cmd_valid=0 the next cycle; state advances on byte_done; max one outstanding command.
REQ-029 byte_done with byte_nack=1 in DEVW/WADDR/WDATA/DEVR -> ack_err=1, go to STOP, then FIN, skipping WR_WAIT.
REQ-030 RDATA byte_done loads rdata from byte_rdata.
REQ-031 WR_WAIT counts exactly WR_WAIT cycles, then FIN.
REQ-032 FIN: done=1 for one cycle, busy=0 the same cycle, return to IDLE; a new request is accepted in the following cycle.
REQ-033 byte_done outside an awaiting state is ignored.

Reset
REQ-034 srst=1: state IDLE; busy, done, ack_err, cmd_valid, cmd_nack = 0; cmd=0; cmd_byte=0; rdata=0; counters 0.
REQ-035 srst mid-transaction aborts at the next edge with no STOP issued; the engine shares srst.

Configuration
REQ-036 Macro EEPROM_CTRL_ACKPOLL_EN defined: WR_WAIT state replaced by polling, START + {DEV_ADDR,0}; on NACK issue STOP and retry; on ACK issue STOP then FIN; after POLL_MAX NACKed polls set ack_err=1 and FIN.
REQ-037 Macro undefined: fixed WR_WAIT delay per REQ-031; poll logic absent.

Structure
REQ-038 Shared package eeprom_pkg: cmd encodings (CMD_START/WRITE/READ/STOP), state enum, DEV_ADDR default.
REQ-039 Sub-module eeprom_wait_cnt: load/enable down-counter with zero flag, used for WR_WAIT.
REQ-040 Single-file FSM otherwise; no combinational path from cmd_ready to cmd_valid.

Verification (bench uses a behavioural byte-engine stub, ready 1 cycle after valid, done 3 cycles after accept)
REQ-041 wr_req, addr=8'h10, wdata=8'hA5, WR_WAIT=20 -> cmd bytes A0,10,A5 in order, STOP, done 20+ cycles after STOP, ack_err=0.
REQ-042 rd_req, addr=8'h10, stub returns 8'h5A -> sequence START,A0,10,START,A1,READ(cmd_nack=1),STOP; rdata=8'h5A, ack_err=0.
REQ-043 Stub NACKs DEVW byte A0 -> STOP issued next, done with ack_err=1, no WADDR command seen.
REQ-044 wr_req and rd_req same cycle, then rd_req while busy -> only one write executes, exactly one done pulse.
REQ-045 srst asserted during WADDR -> next cycle cmd_valid=0, busy=0, all outputs at reset values; subsequent read completes normally.
REQ-046 EEPROM_CTRL_ACKPOLL_EN defined, stub NACKs 3 polls then ACKs -> 4 poll START/A0/STOP groups, done with ack_err=0; POLL_MAX=2 with permanent NACK -> ack_err=1.
